// File: rtl/adc_capture_buffer.sv
// AXI-Stream capture buffer: stores a programmed-length record of ADC samples in a
// read-first BRAM, tracks the signed min/max of the record and counts refused beats.
module adc_capture_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   capture_len,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic [DATA_WIDTH-1:0] rec_min,
  output logic [DATA_WIDTH-1:0] rec_max,
  output logic [31:0]           drop_count,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     wr_count_q, wr_count_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [DATA_WIDTH-1:0]   min_q, min_d;
  logic [DATA_WIDTH-1:0]   max_q, max_d;
  logic                    mm_valid_q, mm_valid_d;
  logic [31:0]             drop_q, drop_d;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [ADDR_WIDTH:0]     len_eff;
  logic                    tready;
  logic                    accept;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   mem_q [0:(1<<ADDR_WIDTH)-1];

  // Handshake: a beat transfers on a rising edge where s_axis_tvalid && s_axis_tready;
  // tready is a pure decode of CAPTURE, so it never depends on tvalid.
  assign tready = (state_q == ST_CAPTURE);
  assign accept = s_axis_tvalid && tready;
  assign len_eff = (capture_len == '0 || capture_len > DEPTH) ? DEPTH : capture_len;

  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    len_d      = len_q;
    min_d      = min_q;
    max_d      = max_q;
    mm_valid_d = mm_valid_q;
    drop_d     = drop_q;
    wr_en      = 1'b0;

    if (s_axis_tvalid && !tready && drop_q != 32'hFFFF_FFFF) begin
      drop_d = drop_q + 32'd1;
    end

    if (arm) begin
      // Restart wins over everything, including a beat offered this cycle.
      state_d    = ST_CAPTURE;
      wr_count_d = '0;
      len_d      = len_eff;
      min_d      = '0;
      max_d      = '0;
      mm_valid_d = 1'b0;
      drop_d     = '0;
    end else begin
      if (accept) begin
        wr_en      = 1'b1;
        wr_count_d = wr_count_q + CNT_ONE;
        mm_valid_d = 1'b1;
        if (!mm_valid_q) begin
          min_d = s_axis_tdata;
          max_d = s_axis_tdata;
        end else begin
          if ($signed(s_axis_tdata) < $signed(min_q)) min_d = s_axis_tdata;
          if ($signed(s_axis_tdata) > $signed(max_q)) max_d = s_axis_tdata;
        end
        if (wr_count_d == len_q) state_d = ST_DONE;
      end
      if (abort && state_q != ST_IDLE) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      wr_count_q <= '0;
      len_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      mm_valid_q <= 1'b0;
      drop_q     <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      len_q      <= len_d;
      min_q      <= min_d;
      max_q      <= max_d;
      mm_valid_q <= mm_valid_d;
      drop_q     <= drop_d;
      rd_data_q  <= mem_q[rd_addr];
    end
  end

  // Storage array is left unreset so it maps onto block RAM.
  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_count_q[ADDR_WIDTH-1:0]] <= s_axis_tdata;
  end

  assign s_axis_tready = tready;
  assign busy          = (state_q == ST_CAPTURE);
  assign done          = (state_q == ST_DONE);
  assign wr_count      = wr_count_q;
  assign rec_min       = min_q;
  assign rec_max       = max_q;
  assign drop_count    = drop_q;
  assign rd_data       = rd_data_q;
  assign dbg_state_o   = state_q;

endmodule
